ntlm_candidate_chunk_gen: RTL and testbench

NTLM_CANDIDATE_CHUNK_GEN -- requirements
Module: ntlm_candidate_chunk_gen

---
 rtl/ntlm_candidate_chunk_gen_if.sv | 27 ++
 rtl/ntlm_candidate_chunk_gen.sv | 133 +++++++++++++
 tb/tb_ntlm_candidate_chunk_gen.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntlm_candidate_chunk_gen_if.sv
// Handshake and configuration bundle for the NTLM candidate chunk generator.
// master: the controller/consumer side, slave: the generator itself.
interface ntlm_candidate_chunk_gen_if #(
    parameter int LEN_W = 5
);
    logic             start;
    logic [15:0]      min_char;
    logic [15:0]      max_char;
    logic [LEN_W-1:0] min_len;
    logic [LEN_W-1:0] max_len;
    logic             chunk_ready;
    logic             chunk_valid;
    logic [511:0]     chunk;
    logic [LEN_W-1:0] cur_len;
    logic             busy;
    logic             done;

    modport master (
        output start, min_char, max_char, min_len, max_len, chunk_ready,
        input  chunk_valid, chunk, cur_len, busy, done
    );

    modport slave (
        input  start, min_char, max_char, min_len, max_len, chunk_ready,
        output chunk_valid, chunk, cur_len, busy, done
    );
endinterface

// File: rtl/ntlm_candidate_chunk_gen.sv
// NTLM candidate chunk generator: sweeps every password over a UTF-16LE
// charset range and length range, presenting each as a padded MD5 block.
// Optional macro NTLM_ALNUM_SKIP_EN: the character increment jumps over the
// gaps between '9'/'A' and 'Z'/'a' so only alphanumerics are produced.
module ntlm_candidate_chunk_gen #(
    parameter int MAX_CHARS = 16,
    parameter int LEN_W     = 5
) (
    input logic                       clk,
    input logic                       reset,
    ntlm_candidate_chunk_gen_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                 state;
    logic                       pend;      // config latched, evaluated next cycle
    logic [15:0]                cfg_min;
    logic [15:0]                cfg_max;
    logic [LEN_W-1:0]           cfg_minl;
    logic [LEN_W-1:0]           cfg_maxl;
    logic [MAX_CHARS-1:0][15:0] chars;
    logic [MAX_CHARS-1:0][15:0] adv_chars;
    logic [LEN_W-1:0]           len;
    logic                       adv_carry;
    logic                       cfg_bad;
    logic [511:0]               chunk_c;

    function automatic logic [15:0] char_inc(input logic [15:0] c);
`ifdef NTLM_ALNUM_SKIP_EN
        if (c == 16'h0039)
            return 16'h0041;
        else if (c == 16'h005A)
            return 16'h0061;
        else
            return c + 16'd1;
`else
        return c + 16'd1;
`endif
    endfunction

    assign cfg_bad = (cfg_minl == '0) || (int'(cfg_maxl) > MAX_CHARS) ||
                     (cfg_minl > cfg_maxl) || (cfg_min > cfg_max);

    // Odometer step: char 0 is least significant. A char counts as "at top"
    // when its successor would pass max_char, so an unreachable max_char
    // (inside a skipped gap) still wraps correctly.
    always_comb begin
        adv_chars = chars;
        adv_carry = 1'b1;
        for (int unsigned i = 0; i < MAX_CHARS; i++) begin
            if (adv_carry && (LEN_W'(i) < len)) begin
                if ((chars[i] == cfg_max) || (char_inc(chars[i]) > cfg_max)) begin
                    adv_chars[i] = cfg_min;
                end else begin
                    adv_chars[i] = char_inc(chars[i]);
                    adv_carry    = 1'b0;
                end
            end
        end
    end

    // Assemble the padded MD5 block from the character registers and length.
    always_comb begin
        chunk_c = '0;
        if (state == S_RUN) begin
            for (int unsigned i = 0; i < MAX_CHARS; i++)
                if (LEN_W'(i) < len)
                    chunk_c[16*i +: 16] = chars[i];
            for (int unsigned i = 1; i <= MAX_CHARS; i++)
                if (LEN_W'(i) == len)
                    chunk_c[16*i +: 8] = 8'h80;
            chunk_c[479:448] = 32'(len) << 4;
        end
    end

    // Control FSM, configuration latch and candidate state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            pend     <= 1'b0;
            cfg_min  <= '0;
            cfg_max  <= '0;
            cfg_minl <= '0;
            cfg_maxl <= '0;
            chars    <= '0;
            len      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pend) begin
                        pend <= 1'b0;
                        if (cfg_bad) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_RUN;
                            len   <= cfg_minl;
                            chars <= {MAX_CHARS{cfg_min}};
                        end
                    end else if (bus.start) begin
                        pend     <= 1'b1;
                        cfg_min  <= bus.min_char;
                        cfg_max  <= bus.max_char;
                        cfg_minl <= bus.min_len;
                        cfg_maxl <= bus.max_len;
                    end
                end
                S_RUN: begin
                    if (bus.chunk_ready) begin
                        if (!adv_carry) begin
                            chars <= adv_chars;
                        end else if (len < cfg_maxl) begin
                            len   <= len + 1'b1;
                            chars <= {MAX_CHARS{cfg_min}};
                        end else begin
                            state <= S_DONE;
                            len   <= '0;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.chunk_valid = (state == S_RUN);
    assign bus.chunk       = chunk_c;
    assign bus.cur_len     = len;
    assign bus.busy        = (state == S_RUN);
    assign bus.done        = (state == S_DONE);
endmodule

// File: tb/tb_ntlm_candidate_chunk_gen.sv
// Directed bench for ntlm_candidate_chunk_gen; expected chunks are built
// from the block format (chars little-endian, 0x80 pad, bit-length field).
module tb_ntlm_candidate_chunk_gen;
    localparam int MAX_CHARS = 16;
    localparam int LEN_W     = 5;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    ntlm_candidate_chunk_gen_if #(.LEN_W(LEN_W)) bus();

    ntlm_candidate_chunk_gen #(
        .MAX_CHARS(MAX_CHARS),
        .LEN_W(LEN_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    function automatic logic [511:0] mk_chunk(input logic [26:0][15:0] ch, input int len);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < len; i++)
            r[16*i +: 16] = ch[i];
        r[16*len +: 8]  = 8'h80;
        r[479:448]      = 32'(16 * len);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle, then scramble the config inputs so that
    // only the latched copy can produce correct results.
    task automatic do_start(input logic [15:0] mn, input logic [15:0] mx,
                            input logic [LEN_W-1:0] ml, input logic [LEN_W-1:0] xl);
        bus.min_char = mn;
        bus.max_char = mx;
        bus.min_len  = ml;
        bus.max_len  = xl;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.min_char = 16'hBEEF;
        bus.max_char = 16'h0001;
        bus.min_len  = 5'd7;
        bus.max_len  = 5'd0;
    endtask

    task automatic test_reset();
        reset            = 1'b0;
        bus.start        = 1'b1;
        bus.chunk_ready  = 1'b1;
        bus.min_char     = 16'h0041;
        bus.max_char     = 16'h0042;
        bus.min_len      = 5'd1;
        bus.max_len      = 5'd1;
        tick();
        tick();
        vectors++; if (bus.chunk !== '0) begin miscompares++; $display("FAIL reset_chunk: got %h, expected 0", bus.chunk); end
        vectors++; if (bus.cur_len !== 5'd0) begin miscompares++; $display("FAIL reset_cur_len: got %0d, expected 0", bus.cur_len); end
        vectors++; if (bus.chunk_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, expected 0", bus.chunk_valid); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b, expected 0", bus.done); end
        bus.start = 1'b0;
        reset     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus.chunk_valid !== 1'b0 || bus.done !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_start_priority[%0d]: got valid=%b done=%b, expected 0/0", i, bus.chunk_valid, bus.done);
            end
        end
    endtask

    task automatic test_single_char();
        logic [26:0][15:0] ch;
        ch = '0;
        bus.chunk_ready = 1'b1;
        do_start(16'h0061, 16'h0061, 5'd1, 5'd3);
        tick();
        for (int L = 1; L <= 3; L++) begin
            ch[L-1] = 16'h0061;
            vectors++;
            if (bus.chunk_valid !== 1'b1 || bus.busy !== 1'b1 || bus.chunk !== mk_chunk(ch, L)) begin
                miscompares++;
                $display("FAIL single_char_len%0d: got valid=%b busy=%b chunk=%h, expected chunk=%h", L, bus.chunk_valid, bus.busy, bus.chunk, mk_chunk(ch, L));
            end
            vectors++;
            if (bus.chunk[479:448] !== 32'(16 * L) || bus.cur_len !== LEN_W'(L)) begin
                miscompares++;
                $display("FAIL single_char_size%0d: got size=%0d cur_len=%0d, expected %0d/%0d", L, bus.chunk[479:448], bus.cur_len, 16 * L, L);
            end
            tick();
        end
        vectors++;
        if (bus.done !== 1'b1 || bus.chunk_valid !== 1'b0 || bus.chunk !== '0) begin
            miscompares++;
            $display("FAIL single_char_done: got done=%b valid=%b chunk_nonzero=%b, expected 1/0/0", bus.done, bus.chunk_valid, |bus.chunk);
        end
        tick();
        vectors++;
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL single_char_done_width: got done=%b, expected 0", bus.done); end
    endtask

    task automatic test_odometer();
        logic [26:0][15:0] ch;
        int k;
        ch = '0;
        k  = 0;
        bus.chunk_ready = 1'b1;
        do_start(16'h0030, 16'h0032, 5'd2, 5'd2);
        tick();
        vectors++;
        if (bus.chunk[39:32] !== 8'h80 || bus.chunk[31:0] !== 32'h0030_0030) begin
            miscompares++;
            $display("FAIL odometer_first: got low=%h pad=%h, expected 00300030/80", bus.chunk[31:0], bus.chunk[39:32]);
        end
        for (int c1 = 0; c1 < 3; c1++) begin
            for (int c0 = 0; c0 < 3; c0++) begin
                ch[0] = 16'h0030 + 16'(c0);
                ch[1] = 16'h0030 + 16'(c1);
                vectors++;
                if (bus.chunk_valid !== 1'b1 || bus.cur_len !== 5'd2 || bus.chunk !== mk_chunk(ch, 2)) begin
                    miscompares++;
                    $display("FAIL odometer[%0d]: got valid=%b len=%0d chunk=%h, expected chunk=%h", k, bus.chunk_valid, bus.cur_len, bus.chunk, mk_chunk(ch, 2));
                end
                k++;
                tick();
            end
        end
        vectors++;
        if (bus.done !== 1'b1 || bus.chunk_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL odometer_done: got done=%b valid=%b, expected 1/0", bus.done, bus.chunk_valid);
        end
        tick();
    endtask

    task automatic test_charset_span();
        logic [26:0][15:0] ch;
        ch = '0;
        bus.chunk_ready = 1'b1;
        do_start(16'h0038, 16'h0062, 5'd1, 5'd1);
        tick();
        for (int c = 16'h0038; c <= 16'h0062; c++) begin
`ifdef NTLM_ALNUM_SKIP_EN
            if ((c > 16'h0039 && c < 16'h0041) || (c > 16'h005A && c < 16'h0061))
                continue;
`endif
            ch[0] = 16'(c);
            vectors++;
            if (bus.chunk_valid !== 1'b1 || bus.chunk !== mk_chunk(ch, 1)) begin
                miscompares++;
                $display("FAIL charset[%h]: got valid=%b chunk=%h, expected chunk=%h", c, bus.chunk_valid, bus.chunk, mk_chunk(ch, 1));
            end
            tick();
        end
        vectors++;
        if (bus.done !== 1'b1 || bus.chunk_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL charset_done: got done=%b valid=%b, expected 1/0", bus.done, bus.chunk_valid);
        end
        tick();
    endtask

    task automatic test_stall();
        logic [26:0][15:0] ch;
        int k;
        ch = '0;
        k  = 0;
        bus.chunk_ready = 1'b1;
        do_start(16'h0030, 16'h0032, 5'd2, 5'd2);
        tick();
        for (int c1 = 0; c1 < 3; c1++) begin
            for (int c0 = 0; c0 < 3; c0++) begin
                ch[0] = 16'h0030 + 16'(c0);
                ch[1] = 16'h0030 + 16'(c1);
                if (k == 3) begin
                    bus.chunk_ready = 1'b0;
                    for (int s = 0; s < 5; s++) begin
                        tick();
                        vectors++;
                        if (bus.chunk_valid !== 1'b1 || bus.cur_len !== 5'd2 || bus.chunk !== mk_chunk(ch, 2)) begin
                            miscompares++;
                            $display("FAIL stall_hold[%0d]: got valid=%b len=%0d chunk=%h, expected chunk=%h", s, bus.chunk_valid, bus.cur_len, bus.chunk, mk_chunk(ch, 2));
                        end
                    end
                    bus.chunk_ready = 1'b1;
                end
                vectors++;
                if (bus.chunk_valid !== 1'b1 || bus.chunk !== mk_chunk(ch, 2)) begin
                    miscompares++;
                    $display("FAIL stall_seq[%0d]: got valid=%b chunk=%h, expected chunk=%h", k, bus.chunk_valid, bus.chunk, mk_chunk(ch, 2));
                end
                k++;
                tick();
            end
        end
        vectors++;
        if (bus.done !== 1'b1) begin miscompares++; $display("FAIL stall_done: got done=%b, expected 1", bus.done); end
        tick();
    endtask

    task automatic test_reject();
        logic [15:0]      rmn[4];
        logic [15:0]      rmx[4];
        logic [LEN_W-1:0] rml[4];
        logic [LEN_W-1:0] rxl[4];
        rmn = '{16'h0030, 16'h0030, 16'h0030, 16'h0032};
        rmx = '{16'h0031, 16'h0031, 16'h0031, 16'h0030};
        rml = '{5'd3, 5'd0, 5'd1, 5'd1};
        rxl = '{5'd2, 5'd2, 5'd17, 5'd1};
        bus.chunk_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            do_start(rmn[t], rmx[t], rml[t], rxl[t]);
            vectors++;
            if (bus.done !== 1'b0 || bus.chunk_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reject_early[%0d]: got done=%b valid=%b, expected 0/0", t, bus.done, bus.chunk_valid);
            end
            tick();
            vectors++;
            if (bus.done !== 1'b1 || bus.chunk_valid !== 1'b0 || bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reject_done[%0d]: got done=%b valid=%b busy=%b, expected 1/0/0", t, bus.done, bus.chunk_valid, bus.busy);
            end
            tick();
            vectors++;
            if (bus.done !== 1'b0 || bus.chunk_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reject_after[%0d]: got done=%b valid=%b, expected 0/0", t, bus.done, bus.chunk_valid);
            end
        end
    endtask

    task automatic test_max_len();
        logic [26:0][15:0] ch;
        ch = '0;
        for (int i = 0; i < MAX_CHARS; i++)
            ch[i] = 16'h005A;
        bus.chunk_ready = 1'b0;
        do_start(16'h005A, 16'h005A, 5'd16, 5'd16);
        tick();
        vectors++;
        if (bus.chunk_valid !== 1'b1 || bus.cur_len !== 5'd16 || bus.chunk !== mk_chunk(ch, 16)) begin
            miscompares++;
            $display("FAIL max_len: got valid=%b len=%0d chunk=%h, expected chunk=%h", bus.chunk_valid, bus.cur_len, bus.chunk, mk_chunk(ch, 16));
        end
        vectors++;
        if (bus.chunk[263:256] !== 8'h80 || bus.chunk[479:448] !== 32'd256) begin
            miscompares++;
            $display("FAIL max_len_pad: got pad=%h size=%0d, expected 80/256", bus.chunk[263:256], bus.chunk[479:448]);
        end
        bus.chunk_ready = 1'b1;
        tick();
        vectors++;
        if (bus.done !== 1'b1 || bus.chunk_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL max_len_done: got done=%b valid=%b, expected 1/0", bus.done, bus.chunk_valid);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        logic [26:0][15:0] ch;
        ch = '0;
        bus.chunk_ready = 1'b1;
        do_start(16'h0041, 16'h0043, 5'd1, 5'd1);
        tick();
        bus.min_char = 16'h0061;
        bus.max_char = 16'h0061;
        bus.min_len  = 5'd2;
        bus.max_len  = 5'd2;
        bus.start    = 1'b1;
        for (int c = 16'h0041; c <= 16'h0043; c++) begin
            ch[0] = 16'(c);
            vectors++;
            if (bus.chunk_valid !== 1'b1 || bus.chunk !== mk_chunk(ch, 1)) begin
                miscompares++;
                $display("FAIL start_ignored[%h]: got valid=%b chunk=%h, expected chunk=%h", c, bus.chunk_valid, bus.chunk, mk_chunk(ch, 1));
            end
            tick();
        end
        vectors++;
        if (bus.done !== 1'b1) begin miscompares++; $display("FAIL start_ignored_done: got done=%b, expected 1", bus.done); end
        tick();
        bus.start = 1'b0;
        tick();
        vectors++;
        if (bus.chunk_valid !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_done: got valid=%b done=%b, expected 0/0", bus.chunk_valid, bus.done);
        end
    endtask

    task automatic test_abort_reset();
        logic [26:0][15:0] ch;
        ch = '0;
        bus.chunk_ready = 1'b1;
        do_start(16'h0030, 16'h0039, 5'd1, 5'd2);
        tick();
        tick();
        ch[0] = 16'h0031;
        vectors++;
        if (bus.chunk !== mk_chunk(ch, 1)) begin
            miscompares++;
            $display("FAIL abort_pre: got %h, expected %h", bus.chunk, mk_chunk(ch, 1));
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (bus.chunk_valid !== 1'b0 || bus.chunk !== '0 || bus.cur_len !== 5'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_reset: got valid=%b len=%0d busy=%b done=%b, expected all 0", bus.chunk_valid, bus.cur_len, bus.busy, bus.done);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (bus.done !== 1'b0 || bus.chunk_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_no_done[%0d]: got done=%b valid=%b, expected 0/0", i, bus.done, bus.chunk_valid);
            end
        end
        do_start(16'h007A, 16'h007A, 5'd1, 5'd1);
        tick();
        ch[0] = 16'h007A;
        vectors++;
        if (bus.chunk_valid !== 1'b1 || bus.cur_len !== 5'd1 || bus.chunk !== mk_chunk(ch, 1)) begin
            miscompares++;
            $display("FAIL abort_restart: got valid=%b len=%0d chunk=%h, expected chunk=%h", bus.chunk_valid, bus.cur_len, bus.chunk, mk_chunk(ch, 1));
        end
        tick();
        vectors++;
        if (bus.done !== 1'b1) begin miscompares++; $display("FAIL abort_restart_done: got done=%b, expected 1", bus.done); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_odometer();
        test_charset_span();
        test_stall();
        test_reject();
        test_max_len();
        test_start_ignored();
        test_abort_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
